// File: rtl/id_decode_pipe.sv
// RV32I decode stage: registered ID/EX output, priority operand forwarding and load-use stall.
// Define ID_ILLEGAL_TRAP_EN to emit unknown opcodes flagged via out_illegal instead of dropping them.
module id_decode_pipe #(
  parameter int XLEN     = 32,
  parameter int FWD_SRCS = 2,
  parameter int LOAD_LAT = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [XLEN-1:0]          in_pc,
  input  logic [31:0]              in_inst,
  output logic [4:0]               rs1_addr,
  output logic [4:0]               rs2_addr,
  input  logic [XLEN-1:0]          rs1_data,
  input  logic [XLEN-1:0]          rs2_data,
  input  logic [FWD_SRCS-1:0]      fwd_wen,
  input  logic [5*FWD_SRCS-1:0]    fwd_addr,
  input  logic [XLEN*FWD_SRCS-1:0] fwd_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          out_pc,
  output logic [3:0]               out_aluop,
  output logic [3:0]               out_alusel,
  output logic [XLEN-1:0]          out_imm,
  output logic [XLEN-1:0]          out_op1,
  output logic [XLEN-1:0]          out_op2,
  output logic                     out_wreg,
  output logic [4:0]               out_wd,
  output logic                     out_illegal
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  logic [6:0] opc;
  logic [4:0] rd, rs1, rs2;
  logic [2:0] f3;
  assign opc      = in_inst[6:0];
  assign rd       = in_inst[11:7];
  assign f3       = in_inst[14:12];
  assign rs1      = in_inst[19:15];
  assign rs2      = in_inst[24:20];
  assign rs1_addr = rs1;
  assign rs2_addr = rs2;

  logic signed [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  assign imm_i = XLEN'($signed(in_inst[31:20]));
  assign imm_s = XLEN'($signed({in_inst[31:25], in_inst[11:7]}));
  assign imm_b = XLEN'($signed({in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0}));
  assign imm_u = XLEN'($signed({in_inst[31:12], 12'b0}));
  assign imm_j = XLEN'($signed({in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0}));

  // Lowest-index matching source wins; x0 is hardwired and data never takes part in the match.
  function automatic logic [XLEN-1:0] fwd_sel(input logic [4:0] rs, input logic [XLEN-1:0] rf);
    logic [XLEN-1:0] val;
    val = rf;
    for (int k = FWD_SRCS - 1; k >= 0; k--) begin
      if (fwd_wen[k] && (fwd_addr[5*k +: 5] == rs)) val = fwd_data[XLEN*k +: XLEN];
    end
    if (rs == 5'd0) val = '0;
    return val;
  endfunction

  logic [3:0]      aluop_d, alusel_d;
  logic [XLEN-1:0] imm_d, op1_d, op2_d;
  logic [4:0]      wd_d;
  logic            use1, use2, wr_cls, wreg_d, ill_d, is_load;

  always_comb begin
    aluop_d = 4'd0;
    imm_d   = '0;
    use1    = 1'b0;
    use2    = 1'b0;
    wr_cls  = 1'b0;
    ill_d   = 1'b0;
    is_load = 1'b0;
    case (opc)
      OPC_LUI:    begin aluop_d = 4'd1; imm_d = imm_u; wr_cls = 1'b1; end
      OPC_AUIPC:  begin aluop_d = 4'd2; imm_d = imm_u; wr_cls = 1'b1; end
      OPC_JAL:    begin aluop_d = 4'd3; imm_d = imm_j; wr_cls = 1'b1; end
      OPC_JALR:   begin aluop_d = 4'd4; imm_d = imm_i; wr_cls = 1'b1; use1 = 1'b1; end
      OPC_BRANCH: begin aluop_d = 4'd5; imm_d = imm_b; use1 = 1'b1; use2 = 1'b1; end
      OPC_LOAD:   begin aluop_d = 4'd6; imm_d = imm_i; wr_cls = 1'b1; use1 = 1'b1; is_load = 1'b1; end
      OPC_STORE:  begin aluop_d = 4'd7; imm_d = imm_s; use1 = 1'b1; use2 = 1'b1; end
      OPC_OPIMM:  begin aluop_d = 4'd8; imm_d = imm_i; wr_cls = 1'b1; use1 = 1'b1; end
      OPC_OP:     begin aluop_d = 4'd9; wr_cls = 1'b1; use1 = 1'b1; use2 = 1'b1; end
      default:    ill_d = 1'b1;
    endcase
    // inst[30] selects SUB/SRA; for OPIMM it is only an opcode bit on the shifts.
    if ((opc == OPC_OP) || ((opc == OPC_OPIMM) && (f3[1:0] == 2'b01)))
      alusel_d = {in_inst[30], f3};
    else
      alusel_d = {1'b0, f3};
    wreg_d = wr_cls && (rd != 5'd0);
    wd_d   = wreg_d ? rd : 5'd0;
    op1_d  = use1 ? fwd_sel(rs1, rs1_data) : '0;
    op2_d  = use2 ? fwd_sel(rs2, rs2_data) : '0;
  end

  logic [4:0] ld_rd_q, ld_rd_d;
  logic [1:0] ld_cnt_q, ld_cnt_d;
  logic       out_valid_q, out_valid_d;
  logic       hazard, accept, keep;

  assign hazard = in_valid && (ld_cnt_q != 2'd0) && (ld_rd_q != 5'd0) &&
                  ((use1 && (rs1 == ld_rd_q)) || (use2 && (rs2 == ld_rd_q)));
  assign in_ready = !rst && !flush && !hazard && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
`ifdef ID_ILLEGAL_TRAP_EN
  assign keep = 1'b1;
`else
  assign keep = !ill_d;
`endif

  always_comb begin
    out_valid_d = out_valid_q;
    ld_cnt_d    = ld_cnt_q;
    ld_rd_d     = ld_rd_q;
    if (flush) begin
      out_valid_d = 1'b0;
      ld_cnt_d    = 2'd0;
    end else begin
      if (accept)         out_valid_d = keep;
      else if (out_ready) out_valid_d = 1'b0;
      if (accept && is_load && (rd != 5'd0)) begin
        ld_rd_d  = rd;
        ld_cnt_d = 2'(LOAD_LAT);
      end else if (out_ready && (ld_cnt_q != 2'd0)) begin
        ld_cnt_d = ld_cnt_q - 2'd1;
      end
    end
  end

  logic [XLEN-1:0] pc_q, imm_q, op1_q, op2_q;
  logic [3:0]      aluop_q, alusel_q;
  logic [4:0]      wd_q;
  logic            wreg_q;

  // ID/EX register boundary
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      ld_cnt_q    <= 2'd0;
      ld_rd_q     <= 5'd0;
      pc_q        <= '0;
      aluop_q     <= 4'd0;
      alusel_q    <= 4'd0;
      imm_q       <= '0;
      op1_q       <= '0;
      op2_q       <= '0;
      wreg_q      <= 1'b0;
      wd_q        <= 5'd0;
    end else begin
      out_valid_q <= out_valid_d;
      ld_cnt_q    <= ld_cnt_d;
      ld_rd_q     <= ld_rd_d;
      if (accept) begin
        pc_q     <= in_pc;
        aluop_q  <= aluop_d;
        alusel_q <= alusel_d;
        imm_q    <= imm_d;
        op1_q    <= op1_d;
        op2_q    <= op2_d;
        wreg_q   <= wreg_d;
        wd_q     <= wd_d;
      end
    end
  end

`ifdef ID_ILLEGAL_TRAP_EN
  logic ill_q;
  always_ff @(posedge clk) begin
    if (rst)         ill_q <= 1'b0;
    else if (accept) ill_q <= ill_d;
  end
  assign out_illegal = ill_q;
`else
  assign out_illegal = 1'b0;
`endif

  assign out_valid  = out_valid_q;
  assign out_pc     = pc_q;
  assign out_aluop  = aluop_q;
  assign out_alusel = alusel_q;
  assign out_imm    = imm_q;
  assign out_op1    = op1_q;
  assign out_op2    = op2_q;
  assign out_wreg   = wreg_q;
  assign out_wd     = wd_q;

endmodule

// File: tb/tb_id_decode_pipe.sv
// Directed bench for id_decode_pipe: expected ID/EX entries queued on acceptance, compared on consumption.
module tb_id_decode_pipe;

  typedef struct packed {
    logic [31:0] pc;
    logic [3:0]  aluop;
    logic [3:0]  alusel;
    logic [31:0] imm;
    logic [31:0] op1;
    logic [31:0] op2;
    logic        wreg;
    logic [4:0]  wd;
    logic        illegal;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_pc, in_inst, rs1_data, rs2_data;
  logic [4:0]  rs1_addr, rs2_addr;
  logic [1:0]  fwd_wen;
  logic [9:0]  fwd_addr;
  logic [63:0] fwd_data;
  logic [31:0] out_pc, out_imm, out_op1, out_op2;
  logic [3:0]  out_aluop, out_alusel;
  logic        out_wreg, out_illegal;
  logic [4:0]  out_wd;

  int   checks = 0;
  int   failures = 0;
  exp_t q[$];
  exp_t cur;
  bit   push_en;
  exp_t snap;

  always #5 clk = ~clk;

  id_decode_pipe #(.XLEN(32), .FWD_SRCS(2), .LOAD_LAT(1)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .fwd_wen(fwd_wen), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_aluop(out_aluop), .out_alusel(out_alusel), .out_imm(out_imm),
    .out_op1(out_op1), .out_op2(out_op2), .out_wreg(out_wreg), .out_wd(out_wd),
    .out_illegal(out_illegal)
  );

  function automatic exp_t mk(input logic [31:0] pc, input logic [3:0] aluop, input logic [3:0] alusel,
                              input logic [31:0] imm, input logic [31:0] op1, input logic [31:0] op2,
                              input logic wreg, input logic [4:0] wd, input logic ill);
    exp_t e;
    e = '{pc, aluop, alusel, imm, op1, op2, wreg, wd, ill};
    return e;
  endfunction

  function automatic exp_t observed();
    exp_t o;
    o = '{out_pc, out_aluop, out_alusel, out_imm, out_op1, out_op2, out_wreg, out_wd, out_illegal};
    return o;
  endfunction

  task automatic check(input string tag, input logic [142:0] obs, input logic [142:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [31:0] pc, input logic [31:0] inst, input exp_t e, input bit push);
    in_valid = 1'b1;
    in_pc    = pc;
    in_inst  = inst;
    cur      = e;
    push_en  = push;
  endtask

  task automatic set_fwd(input logic [1:0] wen, input logic [4:0] a1, input logic [4:0] a0,
                         input logic [31:0] d1, input logic [31:0] d0);
    fwd_wen  = wen;
    fwd_addr = {a1, a0};
    fwd_data = {d1, d0};
  endtask

  // Sample at the falling edge: retire consumed entries, then enqueue the one accepted this cycle.
  task automatic tick(input bit chk_rdy, input logic exp_rdy, input string tag);
    exp_t e;
    @(negedge clk);
    if (chk_rdy) check({"in_ready_", tag}, 143'(in_ready), 143'(exp_rdy));
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      check({"queue_has_entry_", tag}, 143'(q.size() != 0), 143'(1));
      if (q.size() != 0) begin
        e = q.pop_front();
        check({"out_entry_", tag}, observed(), e);
      end
    end
    if (in_valid === 1'b1 && in_ready === 1'b1 && push_en) q.push_back(cur);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
    rs1_data = 32'h0; rs2_data = 32'h0;
    set_fwd(2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
    drive(32'h0, 32'h002081B3, '0, 1'b0);

    // Reset held with a valid instruction presented
    tick(1'b1, 1'b0, "rst0");
    tick(1'b1, 1'b0, "rst1");
    check("reset_outputs", observed(), '0);
    check("reset_valid", 143'(out_valid), 143'(0));
    rst = 1'b0;

    // Back-to-back decodes at full throughput
    rs1_data = 32'h99; rs2_data = 32'h5;
    set_fwd(2'b11, 5'd1, 5'd1, 32'h22, 32'h11);
    drive(32'h100, 32'h002081B3, mk(32'h100, 4'd9, 4'd0, 0, 32'h11, 32'h5, 1, 5'd3, 0), 1'b1);
    tick(1'b1, 1'b1, "add_fwd0");
    set_fwd(2'b10, 5'd2, 5'd1, 32'h22, 32'h11);
    drive(32'h104, 32'h002081B3, mk(32'h104, 4'd9, 4'd0, 0, 32'h99, 32'h22, 1, 5'd3, 0), 1'b1);
    tick(1'b1, 1'b1, "add_fwd1");
    set_fwd(2'b01, 5'd0, 5'd0, 32'h0, 32'hFF);
    rs1_data = 32'h55; rs2_data = 32'h66;
    drive(32'h108, 32'h00000233, mk(32'h108, 4'd9, 4'd0, 0, 0, 0, 1, 5'd4, 0), 1'b1);
    tick(1'b1, 1'b1, "add_x0");
    set_fwd(2'b11, 5'd5, 5'd5, 32'h33, 32'h0);
    rs1_data = 32'h7;
    drive(32'h10C, 32'h00128313, mk(32'h10C, 4'd8, 4'd0, 32'h1, 0, 0, 1, 5'd6, 0), 1'b1);
    tick(1'b1, 1'b1, "addi_zero_fwd");
    set_fwd(2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
    rs1_data = 32'h1000; rs2_data = 32'hBEEF;
    drive(32'h110, 32'h0020A423, mk(32'h110, 4'd7, 4'd2, 32'h8, 32'h1000, 32'hBEEF, 0, 5'd0, 0), 1'b1);
    tick(1'b1, 1'b1, "sw");
    drive(32'h114, 32'h123453B7, mk(32'h114, 4'd1, 4'd5, 32'h12345000, 0, 0, 1, 5'd7, 0), 1'b1);
    tick(1'b1, 1'b1, "lui");
    drive(32'h118, 32'hFFDFF0EF, mk(32'h118, 4'd3, 4'd7, 32'hFFFFFFFC, 0, 0, 1, 5'd1, 0), 1'b1);
    tick(1'b1, 1'b1, "jal");

    // Load-use: exactly one stall cycle and one bubble
    drive(32'h200, 32'h0000A283, mk(32'h200, 4'd6, 4'd2, 0, 32'h1000, 0, 1, 5'd5, 0), 1'b1);
    tick(1'b1, 1'b1, "lw");
    rs1_data = 32'h77;
    drive(32'h204, 32'h00128313, mk(32'h204, 4'd8, 4'd0, 32'h1, 32'h77, 0, 1, 5'd6, 0), 1'b1);
    tick(1'b1, 1'b0, "loaduse_stall");
    check("loaduse_bubble", 143'(out_valid), 143'(0));
    tick(1'b1, 1'b1, "loaduse_accept");
    check("loaduse_valid", 143'(out_valid), 143'(1));
    rs1_data = 32'h1000;
    drive(32'h208, 32'h0000A283, mk(32'h208, 4'd6, 4'd2, 0, 32'h1000, 0, 1, 5'd5, 0), 1'b1);
    tick(1'b1, 1'b1, "lw2");
    rs1_data = 32'h88;
    drive(32'h20C, 32'h00138313, mk(32'h20C, 4'd8, 4'd0, 32'h1, 32'h88, 0, 1, 5'd6, 0), 1'b1);
    tick(1'b1, 1'b1, "indep_nostall");

    // EX backpressure freezes the held load, then flush clears it and its stall
    rs1_data = 32'h1000;
    drive(32'h300, 32'h0000A283, mk(32'h300, 4'd6, 4'd2, 0, 32'h1000, 0, 1, 5'd5, 0), 1'b1);
    tick(1'b1, 1'b1, "lw3");
    snap = observed();
    out_ready = 1'b0;
    rs1_data = 32'h44;
    drive(32'h304, 32'h00128313, mk(32'h304, 4'd8, 4'd0, 32'h1, 32'h44, 0, 1, 5'd6, 0), 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 1'b0, "backpressure");
      check("stall_fields", observed(), snap);
      check("stall_valid", 143'(out_valid), 143'(1));
    end
    flush = 1'b1;
    tick(1'b1, 1'b0, "flush");
    check("flush_valid", 143'(out_valid), 143'(0));
    q.delete();
    flush = 1'b0;
    out_ready = 1'b1;
    tick(1'b1, 1'b1, "after_flush");
    check("after_flush_valid", 143'(out_valid), 143'(1));

    // Shift-immediate selector and unknown opcode
    rs1_data = 32'hAB;
    drive(32'h400, 32'h40315093, mk(32'h400, 4'd8, 4'b1101, 32'h403, 32'hAB, 0, 1, 5'd1, 0), 1'b1);
    tick(1'b1, 1'b1, "srai");
`ifdef ID_ILLEGAL_TRAP_EN
    drive(32'h404, 32'h0000017F, mk(32'h404, 4'd0, 4'd0, 0, 0, 0, 0, 5'd0, 1), 1'b1);
    tick(1'b1, 1'b1, "illegal");
    check("illegal_valid", 143'(out_valid), 143'(1));
`else
    drive(32'h404, 32'h0000017F, '0, 1'b0);
    tick(1'b1, 1'b1, "illegal");
    check("illegal_dropped", 143'(out_valid), 143'(0));
`endif

    in_valid = 1'b0;
    tick(1'b0, 1'b0, "drain0");
    tick(1'b0, 1'b0, "drain1");
    check("drain_valid", 143'(out_valid), 143'(0));
    check("queue_empty", 143'(q.size()), 143'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/id_decode_pipe.md
# id_decode_pipe

Parametrised RV32I decode stage with a registered ID/EX output, N-source operand forwarding and scoreboarded load-use stalling. It sits between IF and EX and replaces the combinational decoder plus external stall signal. Valid/ready handshakes on both sides let IF and EX stall independently. Selectable illegal-opcode flagging is available.

## Interface
- XLEN, 32, datapath width (imm, pc, operands).
- FWD_SRCS, 2, number of forwarding ports; index 0 is youngest and highest priority.
- LOAD_LAT, 1, number of pipeline advances a load result is unforwardable after issue; range 1..3.

- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  kill the held instruction and the scoreboard.
- in_valid  in  1  IF presents an instruction.
- in_ready  out  1  decode accepts this cycle.
- in_pc  in  XLEN  instruction address.
- in_inst  in  32  instruction word.
- rs1_addr, rs2_addr  out  5 each  regfile read addresses, combinational from in_inst[19:15], [24:20].
- rs1_data, rs2_data  in  XLEN each  regfile read data, same cycle.
- fwd_wen  in  FWD_SRCS  forwarding source write-enable.
- fwd_addr  in  5*FWD_SRCS  forwarding destination registers, source k at [5k+4:5k].
- fwd_data  in  XLEN*FWD_SRCS  forwarding data.
- out_valid  out  1  ID/EX register holds a decoded instruction.
- out_ready  in  1  EX consumes this cycle.
- out_pc  out  XLEN  instruction address.
- out_aluop  out  4  class: 0 NOP, 1 LUI, 2 AUIPC, 3 JAL, 4 JALR, 5 BRANCH, 6 LOAD, 7 STORE, 8 OPIMM, 9 OP.
- out_alusel  out  4  {inst[30], funct3} for OP and OPIMM shifts (funct3 001/101); {1'b0, funct3} otherwise.
- out_imm  out  XLEN  sign/zero-extended immediate for the I/S/B/U/J format.
- out_op1, out_op2  out  XLEN each  resolved rs1/rs2 values; 0 when the operand is unused.
- out_wreg  out  1  writes rd.
- out_wd  out  5  rd, or 0 when out_wreg=0.
- out_illegal  out  1  unknown opcode.

## Operation
- Decode is combinational from in_inst and is captured on acceptance: in_valid && in_ready.
- Operand usage:
  - rs1 used by JALR, BRANCH, LOAD, STORE, OPIMM, OP.
  - rs2 used by BRANCH, STORE, OP.
- out_wreg=1 for LUI, AUIPC, JAL, JALR, LOAD, OPIMM, OP, and only when rd!=0.
- Forwarding per used operand: take the lowest k with fwd_wen[k] && fwd_addr[k]==rs && rs!=0. Otherwise use rs*_data. rs==0 always yields 0, and data value is never part of the match.
- Scoreboard: ld_rd (5b), ld_cnt (2b).
  - Accepting a LOAD with rd!=0 sets ld_rd=rd, ld_cnt=LOAD_LAT.
  - Otherwise ld_cnt decrements on every cycle with out_ready=1, saturating at 0.
- hazard = in_valid && ld_cnt!=0 && (used rs1==ld_rd || used rs2==ld_rd), with ld_rd!=0.
- in_ready = !rst && !flush && !hazard && (!out_valid || out_ready).
- Register update priority:
  1. rst or flush: out_valid=0, ld_cnt=0.
  2. Accept: load decoded fields, out_valid=1.
  3. out_ready && no accept: out_valid=0 (bubble).
  4. Otherwise hold.
- Unknown opcode: aluop=0, out_wreg=0, operands unused, out_illegal=1 (see Configuration). Fields are still captured, and out_valid=1.

## Timing
- Reset values: out_valid=0, and every out_* field = 0; ld_cnt=0, ld_rd=0.
- Latency: 1 cycle from acceptance to out_valid.
- Throughput: 1 instruction/cycle with out_ready held high and no hazards.
- Load-use with LOAD_LAT=1 and out_ready=1: a dependent instruction directly after a load sees exactly one bubble and is accepted one cycle later.
- An EX stall (out_ready=0) freezes the output fields and ld_cnt.
- flush together with in_valid: the input is not accepted; out_valid=0 on the next cycle.
- A load accepted while ld_cnt!=0 overwrites the scoreboard with the newer load.
- in_ready is combinational from in_inst, ld_cnt, out_valid, out_ready, and flush. There is no path from in_ready back to in_valid.

## Configuration
- ID_ILLEGAL_TRAP_EN defined: out_illegal asserted as described in Operation.
- ID_ILLEGAL_TRAP_EN undefined:
  - out_illegal is tied to 0.
  - Unknown opcodes produce no output entry: accepted but dropped, so out_valid stays or becomes 0 as for a bubble.

## Test plan
- Reset: assert rst 2 cycles with in_valid=1 -> out_valid=0, all outputs 0, in_ready=0 during rst.
- Forward priority: ADD x3,x1,x2 (0x002081B3) with fwd0={1,x1,0x11}, fwd1={1,x1,0x22}, rs2_data=5 -> out_op1=0x11, out_op2=5, out_alusel=0, out_wd=3.
- x0 / zero data: source registers x0 with fwd0={1,x0,0xFF} -> out_op1=0. Then fwd0={1,x5,0} with rs1=x5, rs1_data=7 -> out_op1=0.
- Load-use: LW x5,0(x1) then ADDI x6,x5,1, LOAD_LAT=1 -> in_ready=0 for exactly one cycle; ADDI accepted next cycle, one bubble on out_valid. ADDI x6,x7,1 after the load -> no stall.
- Backpressure and flush: out_ready=0 for 3 cycles -> outputs stable, in_ready=0. Then flush=1 -> out_valid=0 next cycle and the pending load stall is cleared.
- Shift/illegal: SRAI x1,x2,3 (0x40315093) -> out_alusel=4'b1101, imm low bits 3. Opcode 0x7F -> out_illegal=1, out_wreg=0 when ID_ILLEGAL_TRAP_EN is defined; otherwise no out_valid.
